// File: rtl/uart_fizz_host.sv
// uart_fizz_host: host-side initiator for the UART count protocol.
// Sends "r" then NUM_NEXT x "n", checks each digit reply, reports result.

// 8N1 transmitter, LSB first, line idles high.
module uart_tx #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_busy,
  output logic       o_tx_serial
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

  logic          busy_q, busy_d;
  logic          ser_q, ser_d;
  logic [9:0]    sh_q, sh_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] clk_q, clk_d;

  // frame shifter: load {stop,data,start}, step one bit per CLKS_PER_BIT
  always_comb begin
    busy_d = busy_q;
    ser_d  = ser_q;
    sh_d   = sh_q;
    bit_d  = bit_q;
    clk_d  = clk_q;
    if (!busy_q) begin
      ser_d = 1'b1;
      if (i_tx_valid) begin
        busy_d = 1'b1;
        sh_d   = {1'b1, i_tx_data, 1'b0};
        ser_d  = 1'b0;
        bit_d  = '0;
        clk_d  = '0;
      end
    end else if (clk_q == CLK_LAST) begin
      clk_d = '0;
      if (bit_q == 4'd9) begin
        busy_d = 1'b0;
        ser_d  = 1'b1;
      end else begin
        bit_d = bit_q + 4'd1;
        sh_d  = {1'b1, sh_q[9:1]};
        ser_d = sh_q[1];
      end
    end else begin
      clk_d = clk_q + 1'b1;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      ser_q  <= 1'b1;
      sh_q   <= '1;
      bit_q  <= '0;
      clk_q  <= '0;
    end else begin
      busy_q <= busy_d;
      ser_q  <= ser_d;
      sh_q   <= sh_d;
      bit_q  <= bit_d;
      clk_q  <= clk_d;
    end
  end

  assign o_tx_busy   = busy_q;
  assign o_tx_serial = ser_q;
endmodule

// 8N1 receiver with a two-flop input synchronizer.
module uart_rx #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_serial,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_rx_busy
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CLK_HALF = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  rx_state_t     state_q, state_d;
  logic          s1_q, rx_q;
  logic [CW-1:0] clk_q, clk_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          vld_q, vld_d;
  logic [7:0]    dat_q, dat_d;

  // next-state: find start edge, confirm mid-bit, sample 8 bits, check stop
  always_comb begin
    state_d = state_q;
    clk_d   = clk_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    vld_d   = 1'b0;
    dat_d   = dat_q;
    unique case (state_q)
      RX_IDLE: begin
        if (!rx_q) begin
          state_d = RX_START;
          clk_d   = '0;
        end
      end
      RX_START: begin
        if (clk_q == CLK_HALF) begin
          clk_d   = '0;
          bit_d   = '0;
          state_d = rx_q ? RX_IDLE : RX_DATA;
        end else begin
          clk_d = clk_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (clk_q == CLK_LAST) begin
          clk_d = '0;
          sh_d  = {rx_q, sh_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else bit_d = bit_q + 3'd1;
        end else begin
          clk_d = clk_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (clk_q == CLK_LAST) begin
          clk_d   = '0;
          vld_d   = rx_q;
          dat_d   = rx_q ? sh_q : dat_q;
          state_d = RX_IDLE;
        end else begin
          clk_d = clk_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // state register and synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      s1_q    <= 1'b1;
      rx_q    <= 1'b1;
      clk_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= i_rx_serial;
      rx_q    <= s1_q;
      clk_q   <= clk_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
    end
  end

  assign o_rx_valid = vld_q;
  assign o_rx_data  = dat_q;
  assign o_rx_busy  = (state_q != RX_IDLE);
endmodule

// Command sequencer and reply checker.
module uart_fizz_host #(
  parameter int CLKS_PER_BIT = 2,
  parameter int NUM_NEXT     = 16,
  parameter int CNT_MAX      = 8,
  parameter int TIMEOUT_CLKS = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       rx_phy,
  output logic       tx_phy,
  output logic       rx_busy,
  output logic       tx_busy,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [7:0] o_err_cnt,
  output logic [7:0] o_last_rx
);
  localparam int SW = $clog2(NUM_NEXT + 1);
  localparam int EW = $clog2(CNT_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [7:0] CMD_R = 8'h72;
  localparam logic [7:0] CMD_N = 8'h6E;

  typedef enum logic [1:0] {
    IDLE, SEND, WAIT_RSP, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [SW-1:0] step_q, step_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [7:0]    err_q, err_d;
  logic [7:0]    last_q, last_d;
  logic          err_inc, adv;
  logic          rx_valid;
  logic [7:0]    rx_data;

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk         (clk),
    .rst         (rst),
    .i_tx_valid  (tx_valid_q),
    .i_tx_data   (tx_data_q),
    .o_tx_busy   (tx_busy),
    .o_tx_serial (tx_phy)
  );

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .i_rx_serial (rx_phy),
    .o_rx_valid  (rx_valid),
    .o_rx_data   (rx_data),
    .o_rx_busy   (rx_busy)
  );

  // next-state and outputs; a start coincident with o_done is dropped
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    exp_d      = exp_q;
    step_d     = step_q;
    timer_d    = timer_q;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    last_d     = last_q;
    err_inc    = 1'b0;
    adv        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start && !done_q) begin
          err_d   = '0;
          pass_d  = 1'b0;
          cmd_d   = CMD_R;
          exp_d   = '0;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_valid_d = 1'b1;
          tx_data_d  = cmd_q;
          timer_d    = '0;
          state_d    = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        timer_d = timer_q + 1'b1;
        if (rx_valid) begin
          last_d  = rx_data;
          err_inc = (rx_data != (8'h30 + 8'(exp_q)));
          adv     = 1'b1;
        end else if (timer_q == TW'(TIMEOUT_CLKS - 1)) begin
          last_d  = '0;
          err_inc = 1'b1;
          adv     = 1'b1;
        end
        if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
        if (adv) begin
          if (step_q == SW'(NUM_NEXT)) begin
            state_d = DONE;
          end else begin
            step_d  = step_q + 1'b1;
            cmd_d   = CMD_N;
            exp_d   = (exp_q == EW'(CNT_MAX)) ? '0 : exp_q + 1'b1;
            state_d = SEND;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == 8'd0);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      exp_q      <= '0;
      step_q     <= '0;
      timer_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      exp_q      <= exp_d;
      step_q     <= step_d;
      timer_q    <= timer_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      last_q     <= last_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_pass    = pass_q;
  assign o_err_cnt = err_q;
  assign o_last_rx = last_q;
endmodule

// File: tb/tb_uart_fizz_host.sv
// tb_uart_fizz_host: serial responder model plus run-level scoreboard.
// Second instance with a dead rx line exercises error saturation.
module tb_uart_fizz_host;
  localparam int CPB  = 2;
  localparam int NN   = 10;
  localparam int CMAX = 8;
  localparam int TO   = 96;
  localparam int NN2  = 300;

  logic clk = 0;
  logic rst, i_start, rx_phy;
  logic tx_phy, rx_busy, tx_busy;
  logic o_busy, o_done, o_pass;
  logic [7:0] o_err_cnt, o_last_rx;
  logic start2, rx2;
  logic tx2, rxb2, txb2, busy2, done2, pass2;
  logic [7:0] err2, last2;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int silent_pct, corrupt_pct, bad_idx;
  logic [7:0] cmd_log[$];
  int reply_log[$];

  always #5 clk = ~clk;

  uart_fizz_host #(
    .CLKS_PER_BIT(CPB), .NUM_NEXT(NN),
    .CNT_MAX(CMAX), .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .rx_phy(rx_phy), .tx_phy(tx_phy),
    .rx_busy(rx_busy), .tx_busy(tx_busy),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
    .o_err_cnt(o_err_cnt), .o_last_rx(o_last_rx)
  );

  uart_fizz_host #(
    .CLKS_PER_BIT(CPB), .NUM_NEXT(NN2),
    .CNT_MAX(CMAX), .TIMEOUT_CLKS(16)
  ) dut_sat (
    .clk(clk), .rst(rst), .i_start(start2),
    .rx_phy(rx2), .tx_phy(tx2),
    .rx_busy(rxb2), .tx_busy(txb2),
    .o_busy(busy2), .o_done(done2), .o_pass(pass2),
    .o_err_cnt(err2), .o_last_rx(last2)
  );

  always @(posedge clk) if (o_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // responder: decode a command, reply with its running count digit
  initial begin : responder
    logic [7:0] b, rb;
    int cnt, idx;
    rx_phy = 1'b1;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (tx_phy === 1'b0 && rst === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx_phy;
        end
        repeat (CPB) @(negedge clk);
        cmd_log.push_back(b);
        if (b == 8'h72 || b == 8'h6E) begin
          cnt = (b == 8'h72) ? 0 : ((cnt == CMAX) ? 0 : cnt + 1);
          idx = reply_log.size();
          if ($urandom_range(0, 99) < silent_pct) begin
            reply_log.push_back(-1);
          end else begin
            rb = 8'(8'h30 + cnt);
            if (idx == bad_idx) rb = 8'h35;
            else if ($urandom_range(0, 99) < corrupt_pct)
              rb = 8'(8'h30 + ((cnt + 1 + $urandom_range(0, 8)) % 10));
            reply_log.push_back(int'(rb));
            repeat ($urandom_range(0, 10)) @(negedge clk);
            rx_phy = 1'b0;
            repeat (CPB) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
              rx_phy = rb[i];
              repeat (CPB) @(negedge clk);
            end
            rx_phy = 1'b1;
            repeat (CPB) @(negedge clk);
          end
        end
      end
    end
  end

  task automatic run_case(input string nm, input int sil, input int cor,
                          input int bad, input bit dbl);
    int base, err, last, nbad;
    bit seen;
    cmd_log.delete();
    reply_log.delete();
    silent_pct = sil;
    corrupt_pct = cor;
    bad_idx = bad;
    base = done_cnt;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk({nm, "_busy_rise"}, o_busy, 1);
    chk({nm, "_err_clr"}, {o_pass, o_err_cnt}, 0);
    @(negedge clk);
    chk({nm, "_tx_idle"}, tx_phy, 1);
    @(negedge clk);
    chk({nm, "_tx_start"}, tx_phy, 0);
    seen = 0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clk);
      i_start = dbl && (c == 100);
      if (o_done === 1'b1) seen = 1;
    end
    i_start = 1'b0;
    chk({nm, "_done_seen"}, seen, 1);
    err = 0;
    last = 0;
    foreach (reply_log[k]) begin
      if (reply_log[k] < 0) begin
        err++;
        last = 0;
      end else begin
        if (reply_log[k] != 48 + (k % (CMAX + 1))) err++;
        last = reply_log[k];
      end
    end
    if (err > 255) err = 255;
    chk({nm, "_replies"}, reply_log.size(), NN + 1);
    chk({nm, "_err_cnt"}, o_err_cnt, err);
    chk({nm, "_last_rx"}, o_last_rx, last);
    chk({nm, "_pass"}, o_pass, (err == 0));
    chk({nm, "_busy_fall"}, o_busy, 0);
    nbad = 0;
    foreach (cmd_log[i])
      if (cmd_log[i] != ((i == 0) ? 8'h72 : 8'h6E)) nbad++;
    chk({nm, "_ncmd"}, cmd_log.size(), NN + 1);
    chk({nm, "_cmd_bytes"}, nbad, 0);
    repeat (5) @(negedge clk);
    chk({nm, "_one_done"}, done_cnt - base, 1);
    chk({nm, "_pass_hold"}, o_pass, (err == 0));
  endtask

  initial begin : main
    int base;
    bit seen;
    rst = 1'b1;
    i_start = 1'b0;
    start2 = 1'b0;
    rx2 = 1'b1;
    silent_pct = 0;
    corrupt_pct = 0;
    bad_idx = -1;
    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_pass", o_pass, 0);
    chk("rst_err", o_err_cnt, 0);
    chk("rst_last", o_last_rx, 0);
    chk("rst_tx", tx_phy, 1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    run_case("clean", 0, 0, -1, 0);
    run_case("bad3", 0, 0, 2, 0);
    run_case("silent", 100, 0, -1, 0);
    for (int r = 0; r < 4; r++)
      run_case($sformatf("rand%0d", r), 10, 25, -1, 0);
    run_case("dblstart", 0, 0, -1, 1);

    // reset while the 5th command is on the wire
    cmd_log.delete();
    reply_log.delete();
    silent_pct = 0;
    corrupt_pct = 0;
    bad_idx = -1;
    base = done_cnt;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 5000 && !seen; c++) begin
      @(negedge clk);
      if (cmd_log.size() >= 4 && tx_phy === 1'b0) seen = 1;
    end
    chk("rst5_reach", seen, 1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst5_busy", o_busy, 0);
    chk("rst5_done", o_done, 0);
    chk("rst5_last", o_last_rx, 0);
    chk("rst5_err", o_err_cnt, 0);
    chk("rst5_pass", o_pass, 0);
    repeat (CPB) @(negedge clk);
    chk("rst5_tx_high", tx_phy, 1);
    repeat (60) @(negedge clk);
    chk("rst5_no_done", done_cnt - base, 0);
    run_case("after_rst", 0, 0, -1, 0);

    // dead line on the long run: error count must stick at 255
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    seen = 0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clk);
      if (done2 === 1'b1) seen = 1;
    end
    chk("sat_done_seen", seen, 1);
    chk("sat_err", err2, 255);
    chk("sat_pass", pass2, 0);
    chk("sat_last", last2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
